trap_controller: RTL and testbench

Sequences precise trap entry and return for the core. Arbitrates the execute-stage exception sources (illegal instruction, misalignment, ecall/ebreak) and the external interrupt by fixed RISC-V priority. Holds mepc/mcause/mtval/mtvec/mie/mpie state. Drives pipeline flush, fetch stall and the PC redirect consumed by the hazard unit and fetch stage.

---
 rtl/trap_controller.sv | 211 +++++++++++++++++++++
 tb/tb_trap_controller.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trap_controller.sv
// rtl/trap_controller.sv - precise trap entry/return sequencer with machine-mode trap CSRs
module trap_controller #(
    parameter logic [31:0] RESET_MTVEC  = 32'h0000_0100,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        illegal_inst,
    input  logic        inst_misaligned,
    input  logic        ebreak,
    input  logic        load_misaligned,
    input  logic        store_misaligned,
    input  logic        ecall,
    input  logic [31:0] fault_addr,
    input  logic        irq_ext,
    input  logic        mret,
    input  logic        pipe_ready,
    input  logic        mtvec_we,
    input  logic [31:0] mtvec_wdata,
    input  logic        mie_we,
    input  logic        mie_wdata,
    output logic        flush,
    output logic        busy,
    output logic        redirect,
    output logic [31:0] redirect_target,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic [31:0] mtvec,
    output logic        mie,
    output logic        mpie
);

    localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(FLUSH_CYCLES - 1);
    localparam logic [31:0]   IRQ_CAUSE = 32'h8000_000B;
    localparam logic [31:0]   ALIGN_MASK = ~32'h3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_FLUSH    = 2'd1,
        S_REDIRECT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          ret_sel_q, ret_sel_d;
    logic          flush_q, flush_d;
    logic          busy_q, busy_d;
    logic          redirect_q, redirect_d;
    logic [31:0]   target_q, target_d;
    logic [31:0]   mepc_q, mepc_d;
    logic [31:0]   mcause_q, mcause_d;
    logic [31:0]   mtval_q, mtval_d;
    logic [31:0]   mtvec_q, mtvec_d;
    logic          mie_q, mie_d;
    logic          mpie_q, mpie_d;

    logic        sync_hit;
    logic        take_trap;
    logic        take_mret;
    logic [31:0] sync_cause;
    logic        sync_has_tval;

    // Fixed RISC-V synchronous exception priority, highest first.
    always_comb begin
        sync_cause    = 32'd11;
        sync_has_tval = 1'b0;
        if (inst_misaligned) begin
            sync_cause    = 32'd0;
            sync_has_tval = 1'b1;
        end else if (illegal_inst) begin
            sync_cause = 32'd2;
        end else if (ebreak) begin
            sync_cause = 32'd3;
        end else if (load_misaligned) begin
            sync_cause    = 32'd4;
            sync_has_tval = 1'b1;
        end else if (store_misaligned) begin
            sync_cause    = 32'd6;
            sync_has_tval = 1'b1;
        end
    end

    assign sync_hit  = inst_misaligned | illegal_inst | ebreak |
                       load_misaligned | store_misaligned | ecall;
    // mret outranks a pending interrupt; synchronous exceptions outrank both.
    assign take_trap = (state_q == S_IDLE) && ex_valid &&
                       (sync_hit || (!mret && irq_ext && mie_q));
    assign take_mret = (state_q == S_IDLE) && ex_valid && !sync_hit && mret;

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        ret_sel_d  = ret_sel_q;
        flush_d    = flush_q;
        busy_d     = busy_q;
        redirect_d = redirect_q;
        target_d   = target_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mtval_d    = mtval_q;
        mtvec_d    = mtvec_q;
        mie_d      = mie_q;
        mpie_d     = mpie_q;

        if (mtvec_we) begin
            mtvec_d = mtvec_wdata & ALIGN_MASK;
        end
        if (mie_we) begin
            mie_d = mie_wdata;
        end

        case (state_q)
            S_IDLE: begin
                flush_d    = 1'b0;
                busy_d     = 1'b0;
                redirect_d = 1'b0;
                if (take_trap) begin
                    mepc_d    = ex_pc;
                    mcause_d  = sync_hit ? sync_cause : IRQ_CAUSE;
                    mtval_d   = (sync_hit && sync_has_tval) ? fault_addr : 32'd0;
                    mpie_d    = mie_q;
                    mie_d     = 1'b0;
                    ret_sel_d = 1'b0;
                    count_d   = CNT_INIT;
                    state_d   = S_FLUSH;
                    flush_d   = 1'b1;
                    busy_d    = 1'b1;
                end else if (take_mret) begin
                    mie_d     = mpie_q;
                    mpie_d    = 1'b1;
                    ret_sel_d = 1'b1;
                    count_d   = CNT_INIT;
                    state_d   = S_FLUSH;
                    flush_d   = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            S_FLUSH: begin
                count_d = (count_q == '0) ? '0 : count_q - 1'b1;
                if ((count_q == '0) && pipe_ready) begin
                    state_d    = S_REDIRECT;
                    flush_d    = 1'b0;
                    busy_d     = 1'b1;
                    redirect_d = 1'b1;
                    // Target is latched here, so an mtvec write during REDIRECT cannot disturb it.
                    target_d   = ret_sel_q ? mepc_q : (mtvec_q & ALIGN_MASK);
                end
            end
            S_REDIRECT: begin
                state_d    = S_IDLE;
                flush_d    = 1'b0;
                busy_d     = 1'b0;
                redirect_d = 1'b0;
            end
            default: begin
                state_d    = S_IDLE;
                flush_d    = 1'b0;
                busy_d     = 1'b0;
                redirect_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= S_IDLE;
            count_q    <= '0;
            ret_sel_q  <= 1'b0;
            flush_q    <= 1'b0;
            busy_q     <= 1'b0;
            redirect_q <= 1'b0;
            target_q   <= 32'd0;
            mepc_q     <= 32'd0;
            mcause_q   <= 32'd0;
            mtval_q    <= 32'd0;
            mtvec_q    <= RESET_MTVEC;
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            ret_sel_q  <= ret_sel_d;
            flush_q    <= flush_d;
            busy_q     <= busy_d;
            redirect_q <= redirect_d;
            target_q   <= target_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mtval_q    <= mtval_d;
            mtvec_q    <= mtvec_d;
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
        end
    end

    assign flush           = flush_q;
    assign busy            = busy_q;
    assign redirect        = redirect_q;
    assign redirect_target = target_q;
    assign mepc            = mepc_q;
    assign mcause          = mcause_q;
    assign mtval           = mtval_q;
    assign mtvec           = mtvec_q;
    assign mie             = mie_q;
    assign mpie            = mpie_q;

endmodule

// File: tb/tb_trap_controller.sv
// tb/tb_trap_controller.sv - directed scoreboard bench for trap_controller
module tb_trap_controller;

    logic        CLK;
    logic        RST;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic        illegal_inst;
    logic        inst_misaligned;
    logic        ebreak;
    logic        load_misaligned;
    logic        store_misaligned;
    logic        ecall;
    logic [31:0] fault_addr;
    logic        irq_ext;
    logic        mret;
    logic        pipe_ready;
    logic        mtvec_we;
    logic [31:0] mtvec_wdata;
    logic        mie_we;
    logic        mie_wdata;
    logic        flush;
    logic        busy;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [31:0] mtvec;
    logic        mie;
    logic        mpie;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    trap_controller dut (
        .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .illegal_inst(illegal_inst), .inst_misaligned(inst_misaligned),
        .ebreak(ebreak), .load_misaligned(load_misaligned),
        .store_misaligned(store_misaligned), .ecall(ecall),
        .fault_addr(fault_addr), .irq_ext(irq_ext), .mret(mret),
        .pipe_ready(pipe_ready), .mtvec_we(mtvec_we), .mtvec_wdata(mtvec_wdata),
        .mie_we(mie_we), .mie_wdata(mie_wdata), .flush(flush), .busy(busy),
        .redirect(redirect), .redirect_target(redirect_target), .mepc(mepc),
        .mcause(mcause), .mtval(mtval), .mtvec(mtvec), .mie(mie), .mpie(mpie)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        ex_valid = 0; ex_pc = 0; illegal_inst = 0; inst_misaligned = 0;
        ebreak = 0; load_misaligned = 0; store_misaligned = 0; ecall = 0;
        fault_addr = 0; irq_ext = 0; mret = 0;
        mtvec_we = 0; mtvec_wdata = 0; mie_we = 0; mie_wdata = 0;
    endtask

    task automatic fire();
        step();
        clear_inputs();
    endtask

    task automatic pop_target(input string tag);
        if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL %s observed=%0h expected=<empty scoreboard>", tag, redirect_target);
        end else begin
            check(tag, redirect_target, exp_q.pop_front());
        end
    endtask

    // Called in cycle N+1 after the capture edge; counts flush cycles up to the redirect.
    task automatic expect_redirect(input string tag, input int exp_flush);
        int  nfl  = 0;
        bit  seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (redirect) begin
                seen = 1;
                check({tag, "_flush_len"}, nfl, exp_flush);
                check({tag, "_redir_flush"}, {31'd0, flush}, 32'd0);
                check({tag, "_redir_busy"}, {31'd0, busy}, 32'd1);
                pop_target({tag, "_target"});
            end else begin
                if (flush && busy) nfl++;
                step();
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $error("FAIL %s_timeout observed=no_redirect expected=redirect", tag);
        end else begin
            step();
            check({tag, "_idle_redirect"}, {31'd0, redirect}, 32'd0);
            check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
        end
    endtask

    initial begin
        clear_inputs();
        pipe_ready = 1;
        RST = 1;
        step();
        step();
        RST = 0;
        check("rst_mtvec", mtvec, 32'h100);
        check("rst_mie", {31'd0, mie}, 32'd0);
        check("rst_mpie", {31'd0, mpie}, 32'd0);
        check("rst_strobes", {29'd0, flush, busy, redirect}, 32'd0);
        check("rst_target", redirect_target, 32'd0);
        check("rst_mepc", mepc, 32'd0);
        check("rst_mcause", mcause, 32'd0);
        check("rst_mtval", mtval, 32'd0);

        // Illegal instruction
        ex_valid = 1; ex_pc = 32'h40; illegal_inst = 1; fault_addr = 32'h55;
        exp_q.push_back(32'h100);
        fire();
        check("ill_mcause", mcause, 32'd2);
        check("ill_mepc", mepc, 32'h40);
        check("ill_mtval", mtval, 32'd0);
        check("ill_flush", {31'd0, flush}, 32'd1);
        expect_redirect("ill", 2);

        // Load misaligned beats ecall
        ex_valid = 1; ex_pc = 32'h80; load_misaligned = 1; ecall = 1; fault_addr = 32'h1003;
        exp_q.push_back(32'h100);
        fire();
        check("ldm_mcause", mcause, 32'd4);
        check("ldm_mtval", mtval, 32'h1003);
        check("ldm_mepc", mepc, 32'h80);
        expect_redirect("ldm", 2);

        // Instruction misaligned beats illegal
        ex_valid = 1; ex_pc = 32'h90; inst_misaligned = 1; illegal_inst = 1; fault_addr = 32'h2002;
        exp_q.push_back(32'h100);
        fire();
        check("im_mcause", mcause, 32'd0);
        check("im_mtval", mtval, 32'h2002);
        expect_redirect("im", 2);

        // Ebreak beats store misaligned; no tval
        ex_valid = 1; ex_pc = 32'hA0; ebreak = 1; store_misaligned = 1; fault_addr = 32'h3001;
        exp_q.push_back(32'h100);
        fire();
        check("eb_mcause", mcause, 32'd3);
        check("eb_mtval", mtval, 32'd0);
        expect_redirect("eb", 2);

        // Store misaligned beats ecall
        ex_valid = 1; ex_pc = 32'hB0; store_misaligned = 1; ecall = 1; fault_addr = 32'h4005;
        exp_q.push_back(32'h100);
        fire();
        check("stm_mcause", mcause, 32'd6);
        check("stm_mtval", mtval, 32'h4005);
        expect_redirect("stm", 2);

        // Ecall alone
        ex_valid = 1; ex_pc = 32'hC0; ecall = 1; fault_addr = 32'hDEAD;
        exp_q.push_back(32'h100);
        fire();
        check("ec_mcause", mcause, 32'd11);
        check("ec_mtval", mtval, 32'd0);
        expect_redirect("ec", 2);

        // No valid instruction: sources ignored
        ex_valid = 0; ex_pc = 32'hD0; illegal_inst = 1;
        fire();
        check("nv_flush", {31'd0, flush}, 32'd0);
        check("nv_mepc", mepc, 32'hC0);

        // Interrupt entry
        mie_we = 1; mie_wdata = 1;
        fire();
        check("mie_set", {31'd0, mie}, 32'd1);
        ex_valid = 1; ex_pc = 32'h200; irq_ext = 1;
        exp_q.push_back(32'h100);
        fire();
        check("irq_mcause", mcause, 32'h8000_000B);
        check("irq_mepc", mepc, 32'h200);
        check("irq_mtval", mtval, 32'd0);
        check("irq_mie", {31'd0, mie}, 32'd0);
        check("irq_mpie", {31'd0, mpie}, 32'd1);
        expect_redirect("irq", 2);

        // mret returns to mepc
        ex_valid = 1; ex_pc = 32'h300; mret = 1;
        exp_q.push_back(32'h200);
        fire();
        check("mret_mie", {31'd0, mie}, 32'd1);
        check("mret_mpie", {31'd0, mpie}, 32'd1);
        check("mret_mepc", mepc, 32'h200);
        expect_redirect("mret", 2);

        // Interrupt masked
        mie_we = 1; mie_wdata = 0;
        fire();
        ex_valid = 1; ex_pc = 32'h240; irq_ext = 1;
        fire();
        check("irqm_flush", {31'd0, flush}, 32'd0);
        check("irqm_busy", {31'd0, busy}, 32'd0);

        // mret beats interrupt
        mie_we = 1; mie_wdata = 1;
        fire();
        ex_valid = 1; ex_pc = 32'h250; irq_ext = 1; mret = 1;
        exp_q.push_back(32'h200);
        fire();
        check("mri_mcause", mcause, 32'h8000_000B);
        check("mri_mepc", mepc, 32'h200);
        expect_redirect("mri", 2);

        // Pipe stall holds FLUSH; a second trap inside FLUSH is ignored
        pipe_ready = 0;
        ex_valid = 1; ex_pc = 32'h300; illegal_inst = 1;
        exp_q.push_back(32'h100);
        fire();
        for (int i = 0; i < 5; i++) begin
            check("stall_flush", {31'd0, flush}, 32'd1);
            check("stall_redirect", {31'd0, redirect}, 32'd0);
            if (i == 2) begin
                ex_valid = 1; ex_pc = 32'h500; ecall = 1;
            end
            fire();
        end
        pipe_ready = 1;
        step();
        check("stall_rel_redirect", {31'd0, redirect}, 32'd1);
        pop_target("stall_target");
        check("stall_mepc", mepc, 32'h300);
        check("stall_mcause", mcause, 32'd2);
        step();
        check("stall_idle", {30'd0, busy, redirect}, 32'd0);

        // mtvec write forces alignment
        mtvec_we = 1; mtvec_wdata = 32'h303;
        fire();
        check("mtvec_wr", mtvec, 32'h300);
        ex_valid = 1; ex_pc = 32'h600; ecall = 1;
        exp_q.push_back(32'h300);
        fire();
        expect_redirect("vec", 2);

        // mie write on a capture cycle is dropped
        mie_we = 1; mie_wdata = 1;
        fire();
        ex_valid = 1; ex_pc = 32'h610; illegal_inst = 1; mie_we = 1; mie_wdata = 1;
        exp_q.push_back(32'h300);
        fire();
        check("miecap_mie", {31'd0, mie}, 32'd0);
        check("miecap_mpie", {31'd0, mpie}, 32'd1);
        expect_redirect("miecap", 2);

        // mtvec write during the redirect cycle
        ex_valid = 1; ex_pc = 32'h700; illegal_inst = 1;
        exp_q.push_back(32'h300);
        fire();
        step();
        step();
        check("rw_redirect", {31'd0, redirect}, 32'd1);
        pop_target("rw_target");
        mtvec_we = 1; mtvec_wdata = 32'h400;
        fire();
        check("rw_mtvec", mtvec, 32'h400);
        check("rw_idle", {31'd0, redirect}, 32'd0);

        // Asynchronous reset mid-FLUSH
        ex_valid = 1; ex_pc = 32'h800; illegal_inst = 1;
        fire();
        check("arst_pre_flush", {31'd0, flush}, 32'd1);
        RST = 1;
        #2;
        check("arst_flush", {31'd0, flush}, 32'd0);
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_mtvec", mtvec, 32'h100);
        check("arst_mepc", mepc, 32'd0);
        step();
        RST = 0;
        step();
        step();
        check("arst_idle", {29'd0, flush, busy, redirect}, 32'd0);

        check("sb_empty", exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
